// File: rtl/dbgu_cmd_engine_pkg.sv
// Shared definitions for the debug-unit command engine: host opcodes, FSM states, timeout fill byte.
package dbgu_cmd_engine_pkg;

    localparam logic [7:0] OP_SET_ADDR  = 8'h01;
    localparam logic [7:0] OP_WRITE     = 8'h04;
    localparam logic [7:0] OP_READ      = 8'h05;
    localparam logic [7:0] OP_CPU_CLK   = 8'h22;
    localparam logic [7:0] TIMEOUT_FILL = 8'hEE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARG,
        S_EXEC_SET,
        S_MEM_WR,
        S_MEM_RD,
        S_TX
    } engine_state_t;

    // Command whose argument bytes are being collected in S_ARG.
    typedef enum logic [1:0] {
        CMD_SET_ADDR,
        CMD_WRITE,
        CMD_CPU_CLK
    } arg_cmd_t;

    function automatic logic [31:0] next_word_addr(input logic [31:0] addr);
        return {addr[31:2] + 30'd1, 2'b00};
    endfunction

endpackage

// File: rtl/dbgu_cmd_engine_if.sv
// Byte-stream (UART RX/TX) and picorv32-native memory port bundle of the debug command engine.
interface dbgu_cmd_engine_if;

    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        cpu_run;

    modport master (
        input  rx_valid, rx_data, tx_ready, mem_ready, mem_rdata,
        output rx_ready, tx_valid, tx_data, mem_valid, mem_addr, mem_wdata, mem_wstrb, cpu_run
    );

    modport slave (
        output rx_valid, rx_data, tx_ready, mem_ready, mem_rdata,
        input  rx_ready, tx_valid, tx_data, mem_valid, mem_addr, mem_wdata, mem_wstrb, cpu_run
    );

endinterface

// File: rtl/dbgu_cmd_engine_word_shifter.sv
// dbgu_word_shifter: 32-bit little-endian byte assembler (shift-in) and byte serializer (indexed read-out).
module dbgu_word_shifter (
    input  logic        clk,
    input  logic        reset,
    input  logic        shift_en,
    input  logic [7:0]  shift_byte,
    input  logic        load_en,
    input  logic [31:0] load_word,
    input  logic [1:0]  rd_idx,
    output logic [31:0] word,
    output logic [7:0]  rd_byte
);

    // New bytes enter at the top, so after four shifts the first byte sits in [7:0].
    always_ff @(posedge clk) begin
        if (reset) begin
            word <= '0;
        end else if (load_en) begin
            word <= load_word;
        end else if (shift_en) begin
            word <= {shift_byte, word[31:8]};
        end
    end

    assign rd_byte = word[{rd_idx, 3'b000} +: 8];

endmodule

// File: rtl/dbgu_cmd_engine.sv
// Debug-unit command engine: decodes host bytes into word accesses and streams read data back.
// Optional CPU clock gating command is enabled by defining DBGU_CPU_HALT_EN.
module dbgu_cmd_engine
    import dbgu_cmd_engine_pkg::*;
#(
    parameter logic [31:0] ADDR_RESET  = 32'h0000_0000,
    parameter logic [15:0] MEM_TIMEOUT = 16'd1023
) (
    input logic               clk,
    input logic               reset,
    dbgu_cmd_engine_if.master bus
);

    engine_state_t state, state_next;
    arg_cmd_t      cmd, cmd_next;

    logic [1:0]  byte_cnt;
    logic [1:0]  last_idx;
    logic        cnt_clr, cnt_inc;
    logic [31:0] addr_ptr;
    logic        ptr_set, ptr_inc;
    logic [15:0] tmo_cnt;
    logic        tmo_clr, tmo_inc, timed_out;
    logic        shift_en, load_en;
    logic [31:0] load_word, word;
    logic [7:0]  tx_byte;
    logic        rx_ready, tx_valid, mem_valid;
    logic [3:0]  mem_wstrb;
`ifdef DBGU_CPU_HALT_EN
    logic        cpu_set;
    logic        cpu_run_q;
`endif

    dbgu_word_shifter u_shifter (
        .clk        (clk),
        .reset      (reset),
        .shift_en   (shift_en),
        .shift_byte (bus.rx_data),
        .load_en    (load_en),
        .load_word  (load_word),
        .rd_idx     (byte_cnt),
        .word       (word),
        .rd_byte    (tx_byte)
    );

    assign last_idx  = (cmd == CMD_CPU_CLK) ? 2'd0 : 2'd3;
    assign timed_out = (MEM_TIMEOUT != 16'd0) && (tmo_cnt == MEM_TIMEOUT - 16'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cmd_next   = cmd;
        rx_ready   = 1'b0;
        tx_valid   = 1'b0;
        mem_valid  = 1'b0;
        mem_wstrb  = 4'h0;
        shift_en   = 1'b0;
        load_en    = 1'b0;
        load_word  = bus.mem_rdata;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        ptr_set    = 1'b0;
        ptr_inc    = 1'b0;
        tmo_clr    = 1'b1;
        tmo_inc    = 1'b0;
`ifdef DBGU_CPU_HALT_EN
        cpu_set    = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                rx_ready = 1'b1;
                if (bus.rx_valid) begin
                    cnt_clr = 1'b1;
                    case (bus.rx_data)
                        OP_SET_ADDR: begin
                            cmd_next   = CMD_SET_ADDR;
                            state_next = S_ARG;
                        end
                        OP_WRITE: begin
                            cmd_next   = CMD_WRITE;
                            state_next = S_ARG;
                        end
                        OP_READ: state_next = S_MEM_RD;
`ifdef DBGU_CPU_HALT_EN
                        OP_CPU_CLK: begin
                            cmd_next   = CMD_CPU_CLK;
                            state_next = S_ARG;
                        end
`endif
                        default: state_next = S_IDLE;
                    endcase
                end
            end
            S_ARG: begin
                rx_ready = 1'b1;
                if (bus.rx_valid) begin
                    shift_en = 1'b1;
                    if (byte_cnt == last_idx) begin
                        cnt_clr = 1'b1;
                        case (cmd)
                            CMD_SET_ADDR: state_next = S_EXEC_SET;
                            CMD_WRITE:    state_next = S_MEM_WR;
`ifdef DBGU_CPU_HALT_EN
                            CMD_CPU_CLK: begin
                                cpu_set    = 1'b1;
                                state_next = S_IDLE;
                            end
`endif
                            default:      state_next = S_IDLE;
                        endcase
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            S_EXEC_SET: begin
                ptr_set    = 1'b1;
                state_next = S_IDLE;
            end
            S_MEM_WR: begin
                mem_valid = 1'b1;
                mem_wstrb = 4'hF;
                tmo_clr   = 1'b0;
                if (bus.mem_ready) begin
                    ptr_inc    = 1'b1;
                    state_next = S_IDLE;
                end else if (timed_out) begin
                    state_next = S_IDLE;
                end else begin
                    tmo_inc = 1'b1;
                end
            end
            S_MEM_RD: begin
                mem_valid = 1'b1;
                tmo_clr   = 1'b0;
                if (bus.mem_ready) begin
                    load_en    = 1'b1;
                    ptr_inc    = 1'b1;
                    cnt_clr    = 1'b1;
                    state_next = S_TX;
                end else if (timed_out) begin
                    // An abandoned read still answers the host with a recognisable filler word.
                    load_en    = 1'b1;
                    load_word  = {4{TIMEOUT_FILL}};
                    cnt_clr    = 1'b1;
                    state_next = S_TX;
                end else begin
                    tmo_inc = 1'b1;
                end
            end
            S_TX: begin
                tx_valid = 1'b1;
                if (bus.tx_ready) begin
                    if (byte_cnt == 2'd3) begin
                        cnt_clr    = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd      <= CMD_SET_ADDR;
            byte_cnt <= 2'd0;
            addr_ptr <= {ADDR_RESET[31:2], 2'b00};
            tmo_cnt  <= 16'd0;
        end else begin
            cmd <= cmd_next;
            if (cnt_clr) begin
                byte_cnt <= 2'd0;
            end else if (cnt_inc) begin
                byte_cnt <= byte_cnt + 2'd1;
            end
            if (ptr_set) begin
                addr_ptr <= {word[31:2], 2'b00};
            end else if (ptr_inc) begin
                addr_ptr <= next_word_addr(addr_ptr);
            end
            if (tmo_clr) begin
                tmo_cnt <= 16'd0;
            end else if (tmo_inc) begin
                tmo_cnt <= tmo_cnt + 16'd1;
            end
        end
    end

`ifdef DBGU_CPU_HALT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_run_q <= 1'b1;
        end else if (cpu_set) begin
            cpu_run_q <= bus.rx_data[0];
        end
    end
    assign bus.cpu_run = cpu_run_q;
`else
    assign bus.cpu_run = 1'b1;
`endif

    // rx_ready is masked during reset so no byte is consumed while the engine is being cleared.
    assign bus.rx_ready  = rx_ready & ~reset;
    assign bus.tx_valid  = tx_valid;
    assign bus.tx_data   = tx_valid ? tx_byte : 8'h00;
    assign bus.mem_valid = mem_valid;
    assign bus.mem_addr  = addr_ptr;
    assign bus.mem_wdata = (state == S_MEM_WR) ? word : 32'h0;
    assign bus.mem_wstrb = mem_wstrb;

endmodule

// File: tb/tb_dbgu_cmd_engine.sv
// Self-checking bench for dbgu_cmd_engine: directed and randomized host commands against a
// transaction-level model of the address pointer, memory contents and CPU run flag.
module tb_dbgu_cmd_engine;
    import dbgu_cmd_engine_pkg::*;

    localparam logic [15:0] TMO = 16'd24;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    dbgu_cmd_engine_if bus ();

    dbgu_cmd_engine #(
        .ADDR_RESET  (32'h0000_0000),
        .MEM_TIMEOUT (TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [31:0] ptr_model;
    logic        cpu_run_model;
    logic [31:0] mem_model [logic [31:0]];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    // Offer one byte on RX (called at a negedge) and return at the negedge after it is taken.
    task automatic applyStimulus(input logic [7:0] b);
        int n = 0;
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        while (bus.rx_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("rx_ready_wait", {31'h0, bus.rx_ready}, 32'h1);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
    endtask

    task automatic serviceMem(input bit is_wr, input logic [31:0] wdata, input int lat,
                              input logic [31:0] rdata);
        for (int i = 0; i <= lat; i++) begin
            if (i > 0) @(negedge clk);
            checkOutput("mem_valid", {31'h0, bus.mem_valid}, 32'h1);
            checkOutput("mem_addr", bus.mem_addr, ptr_model);
            checkOutput("mem_wstrb", {28'h0, bus.mem_wstrb}, is_wr ? 32'hF : 32'h0);
            if (is_wr) checkOutput("mem_wdata", bus.mem_wdata, wdata);
        end
        bus.mem_ready = 1'b1;
        bus.mem_rdata = rdata;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        bus.mem_rdata = $urandom;
        checkOutput("mem_valid_drop", {31'h0, bus.mem_valid}, 32'h0);
    endtask

    // Drain bytes with random tx_ready while a READ opcode waits on RX and must not be taken.
    task automatic collectTx(input logic [31:0] word, input int nbytes);
        int k = 0;
        int n = 0;
        logic [7:0] exp_b;
        bus.rx_valid = 1'b1;
        bus.rx_data  = OP_READ;
        while (k < nbytes && n < 400) begin
            bus.tx_ready = 1'($urandom_range(0, 1));
            if (bus.tx_valid === 1'b1) begin
                exp_b = word[k*8 +: 8];
                checkOutput("tx_data", {24'h0, bus.tx_data}, {24'h0, exp_b});
                checkOutput("rx_ready_in_tx", {31'h0, bus.rx_ready}, 32'h0);
                if (bus.tx_ready) k++;
            end
            @(negedge clk);
            n++;
        end
        bus.tx_ready = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        checkOutput("tx_count", k, nbytes);
    endtask

    task automatic doSetAddr(input logic [31:0] a);
        applyStimulus(OP_SET_ADDR);
        for (int i = 0; i < 4; i++) applyStimulus(a[i*8 +: 8]);
        ptr_model = a & 32'hFFFF_FFFC;
        checkOutput("set_no_mem", {31'h0, bus.mem_valid}, 32'h0);
        checkOutput("set_no_tx", {31'h0, bus.tx_valid}, 32'h0);
        @(negedge clk);
    endtask

    task automatic doWrite(input logic [31:0] d, input int lat);
        applyStimulus(OP_WRITE);
        for (int i = 0; i < 4; i++) applyStimulus(d[i*8 +: 8]);
        serviceMem(1'b1, d, lat, $urandom);
        mem_model[ptr_model] = d;
        ptr_model = ptr_model + 32'd4;
        checkOutput("wr_no_tx", {31'h0, bus.tx_valid}, 32'h0);
    endtask

    task automatic doRead(input int lat);
        logic [31:0] rd;
        applyStimulus(OP_READ);
        rd = mem_read(ptr_model);
        serviceMem(1'b0, 32'h0, lat, rd);
        ptr_model = ptr_model + 32'd4;
        collectTx(rd, 4);
        checkOutput("rd_tx_done", {31'h0, bus.tx_valid}, 32'h0);
    endtask

    task automatic waitTimeout();
        for (int i = 0; i < int'(TMO); i++) begin
            if (i > 0) @(negedge clk);
            checkOutput("tmo_mem_valid", {31'h0, bus.mem_valid}, 32'h1);
        end
        @(negedge clk);
        checkOutput("tmo_mem_drop", {31'h0, bus.mem_valid}, 32'h0);
    endtask

    task automatic doReadTimeout();
        applyStimulus(OP_READ);
        waitTimeout();
        checkOutput("tmo_rd_tx", {31'h0, bus.tx_valid}, 32'h1);
        collectTx({4{TIMEOUT_FILL}}, 4);
        checkOutput("tmo_rd_done", {31'h0, bus.tx_valid}, 32'h0);
    endtask

    task automatic doWriteTimeout(input logic [31:0] d);
        applyStimulus(OP_WRITE);
        for (int i = 0; i < 4; i++) applyStimulus(d[i*8 +: 8]);
        waitTimeout();
        checkOutput("tmo_wr_no_tx", {31'h0, bus.tx_valid}, 32'h0);
    endtask

    task automatic cpuClk(input logic [7:0] arg);
        applyStimulus(OP_CPU_CLK);
        applyStimulus(arg);
`ifdef DBGU_CPU_HALT_EN
        cpu_run_model = arg[0];
`endif
        checkOutput("cpu_run", {31'h0, bus.cpu_run}, {31'h0, cpu_run_model});
        checkOutput("cpu_no_mem", {31'h0, bus.mem_valid}, 32'h0);
    endtask

    task automatic pulseReset();
        bus.rx_valid  = 1'b0;
        bus.tx_ready  = 1'b0;
        bus.mem_ready = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rst_rx_ready", {31'h0, bus.rx_ready}, 32'h0);
        checkOutput("rst_tx_valid", {31'h0, bus.tx_valid}, 32'h0);
        checkOutput("rst_tx_data", {24'h0, bus.tx_data}, 32'h0);
        checkOutput("rst_mem_valid", {31'h0, bus.mem_valid}, 32'h0);
        checkOutput("rst_mem_wdata", bus.mem_wdata, 32'h0);
        checkOutput("rst_mem_wstrb", {28'h0, bus.mem_wstrb}, 32'h0);
        checkOutput("rst_cpu_run", {31'h0, bus.cpu_run}, 32'h1);
        checkOutput("rst_mem_addr", bus.mem_addr, 32'h0);
        reset = 1'b0;
        ptr_model     = 32'h0;
        cpu_run_model = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL global_timeout: simulation did not complete");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        logic [31:0] rd;
        bus.rx_valid  = 1'b0;
        bus.rx_data   = 8'h00;
        bus.tx_ready  = 1'b0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0;
        ptr_model     = 32'h0;
        cpu_run_model = 1'b1;
        @(negedge clk);
        @(negedge clk);
        pulseReset();

        // Basic set / write / read-back flow.
        doSetAddr(32'h0002_0000);
        doWrite(32'hAABB_CCDD, 0);
        doWrite(32'hAA80_AA80, 2);
        doSetAddr(32'h0002_0000);
        doRead(0);
        doRead(1);

        // Slow memory responses.
        doWrite(32'h1234_5678, 5);
        doSetAddr(32'h0002_0008);
        doRead(5);

        // Pointer wrap at the top of the address space.
        doSetAddr(32'hFFFF_FFFC);
        doWrite(32'hCAFE_F00D, 1);
        doRead(0);
        doSetAddr(32'hFFFF_FFFF);
        doRead(3);

        // Unknown opcode plus stray mem_ready while idle.
        bus.mem_ready = 1'b1;
        applyStimulus(8'h7F);
        checkOutput("unk_no_mem", {31'h0, bus.mem_valid}, 32'h0);
        checkOutput("unk_no_tx", {31'h0, bus.tx_valid}, 32'h0);
        checkOutput("unk_idle", {31'h0, bus.rx_ready}, 32'h1);
        bus.mem_ready = 1'b0;
        @(negedge clk);
        doRead(0);

        // Abandoned accesses leave the pointer where it was.
        doSetAddr(32'h0002_0000);
        doReadTimeout();
        doRead(0);
        doWriteTimeout(32'h0BAD_BEEF);
        doRead(0);

`ifdef DBGU_CPU_HALT_EN
        cpuClk(8'h00);
        cpuClk(8'h01);
        cpuClk(8'h00);
`else
        cpuClk(8'h00);
        applyStimulus(OP_CPU_CLK);
        doSetAddr(32'h0002_0004);
        doRead(2);
`endif

        // Reset while collecting WRITE arguments: the next byte is a fresh opcode.
        applyStimulus(OP_WRITE);
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        pulseReset();
        doRead(1);

        // Reset in the middle of a read response.
        doSetAddr(32'h0002_0000);
        applyStimulus(OP_READ);
        rd = mem_read(ptr_model);
        serviceMem(1'b0, 32'h0, 0, rd);
        collectTx(rd, 2);
        pulseReset();
        doRead(0);

        for (int it = 0; it < 24; it++) begin
            case ($urandom_range(0, 2))
                0:       doSetAddr(32'h0000_1000 + 32'($urandom_range(0, 63)));
                1:       doWrite($urandom, int'($urandom_range(0, 6)));
                default: doRead(int'($urandom_range(0, 6)));
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
